// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares one backing DRAM port between the icache refill path (read-only)
//   and the dcache path (read / write-back). Round-robin arbitration, one
//   outstanding transaction, registered DRAM request and responses, and a
//   sticky timeout flag for debug.
//
// Ports:
//   i_riscv_arb_clk / i_riscv_arb_rst   clock, asynchronous active-high reset
//   i_riscv_arb_imem_*                  icache request (level) / ready pulse / read block
//   i_riscv_arb_dmem_*                  dcache request (level) / ready pulse / read block
//   o_riscv_arb_mem_*, i_riscv_arb_mem_* DRAM request (registered) and response
//   o_riscv_arb_grant                   01 = icache granted, 10 = dcache granted
//   o_riscv_arb_timeout                 sticky: a grant lasted TIMEOUT_CYC cycles
module riscv_mem_arbiter #(
  parameter int DATA_WIDTH  = 128,
  parameter int S_ADDR      = 10,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  i_riscv_arb_clk,
  input  logic                  i_riscv_arb_rst,
  input  logic                  i_riscv_arb_imem_rden,
  input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
  output logic                  o_riscv_arb_imem_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_rdata,
  input  logic                  i_riscv_arb_dmem_rden,
  input  logic                  i_riscv_arb_dmem_wren,
  input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_wdata,
  output logic                  o_riscv_arb_dmem_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_rdata,
  output logic                  o_riscv_arb_mem_rden,
  output logic                  o_riscv_arb_mem_wren,
  output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata,
  input  logic                  i_riscv_arb_mem_ready,
  output logic [1:0]            o_riscv_arb_grant,
  output logic                  o_riscv_arb_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  // last-grant encoding: reset to I so that D wins the first tie
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                r_state,       w_state_next;
  logic                  r_last_grant,  w_last_grant_next;
  logic                  r_mem_rden,    w_mem_rden_next;
  logic                  r_mem_wren,    w_mem_wren_next;
  logic [S_ADDR-1:0]     r_mem_addr,    w_mem_addr_next;
  logic [DATA_WIDTH-1:0] r_mem_wdata,   w_mem_wdata_next;
  logic                  r_imem_ready,  w_imem_ready_next;
  logic                  r_dmem_ready,  w_dmem_ready_next;
  logic [DATA_WIDTH-1:0] r_imem_rdata,  w_imem_rdata_next;
  logic [DATA_WIDTH-1:0] r_dmem_rdata,  w_dmem_rdata_next;
  logic [CNT_W-1:0]      r_cnt,         w_cnt_next;
  logic                  r_timeout,     w_timeout_next;

  logic                  w_i_req;
  logic                  w_d_req;
  logic [CNT_W-1:0]      w_cnt_inc;

  assign w_i_req   = i_riscv_arb_imem_rden;
  assign w_d_req   = i_riscv_arb_dmem_rden | i_riscv_arb_dmem_wren;
  // saturating grant-cycle counter; the grant itself is never aborted
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // state and registered outputs
  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LG_I;
      r_mem_rden   <= 1'b0;
      r_mem_wren   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_imem_ready <= 1'b0;
      r_dmem_ready <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_mem_rden   <= w_mem_rden_next;
      r_mem_wren   <= w_mem_wren_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_imem_ready <= w_imem_ready_next;
      r_dmem_ready <= w_dmem_ready_next;
      r_imem_rdata <= w_imem_rdata_next;
      r_dmem_rdata <= w_dmem_rdata_next;
      r_cnt        <= w_cnt_next;
      r_timeout    <= w_timeout_next;
    end
  end

  // next-state and next-output logic
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_mem_rden_next   = r_mem_rden;
    w_mem_wren_next   = r_mem_wren;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_imem_ready_next = 1'b0;
    w_dmem_ready_next = 1'b0;
    w_imem_rdata_next = r_imem_rdata;
    w_dmem_rdata_next = r_dmem_rdata;
    w_cnt_next        = r_cnt;
    w_timeout_next    = r_timeout;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        // I wins when it is alone, or on a tie when D was served last
        if (w_i_req && (!w_d_req || r_last_grant == LG_D)) begin
          w_state_next      = ST_GRANT_I;
          w_last_grant_next = LG_I;
          w_mem_addr_next   = i_riscv_arb_imem_addr;
          w_mem_rden_next   = 1'b1;
          w_mem_wren_next   = 1'b0;
        end else if (w_d_req) begin
          w_state_next      = ST_GRANT_D;
          w_last_grant_next = LG_D;
          w_mem_addr_next   = i_riscv_arb_dmem_addr;
          w_mem_wdata_next  = i_riscv_arb_dmem_wdata;
          // write wins when both rden and wren are set; op is fixed for the grant
          w_mem_wren_next   = i_riscv_arb_dmem_wren;
          w_mem_rden_next   = ~i_riscv_arb_dmem_wren;
        end
      end

      ST_GRANT_I, ST_GRANT_D: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc == CNT_MAX) begin
          w_timeout_next = 1'b1;
        end
        if (i_riscv_arb_mem_ready) begin
          w_state_next    = ST_RELEASE;
          w_mem_rden_next = 1'b0;
          w_mem_wren_next = 1'b0;
          if (r_state == ST_GRANT_I) begin
            w_imem_ready_next = 1'b1;
            w_imem_rdata_next = i_riscv_arb_mem_rdata;
          end else begin
            w_dmem_ready_next = 1'b1;
            // r_mem_wren still holds the op latched at grant
            if (!r_mem_wren) begin
              w_dmem_rdata_next = i_riscv_arb_mem_rdata;
            end
          end
        end
      end

      ST_RELEASE: begin
        // one forced idle memory cycle lets the DRAM rearm and the requester drop
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_riscv_arb_imem_ready = r_imem_ready;
  assign o_riscv_arb_imem_rdata = r_imem_rdata;
  assign o_riscv_arb_dmem_ready = r_dmem_ready;
  assign o_riscv_arb_dmem_rdata = r_dmem_rdata;
  assign o_riscv_arb_mem_rden   = r_mem_rden;
  assign o_riscv_arb_mem_wren   = r_mem_wren;
  assign o_riscv_arb_mem_addr   = r_mem_addr;
  assign o_riscv_arb_mem_wdata  = r_mem_wdata;
  assign o_riscv_arb_timeout    = r_timeout;
  assign o_riscv_arb_grant      = (r_state == ST_GRANT_I) ? 2'b01 :
                                  (r_state == ST_GRANT_D) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//   Directed and randomized bench for riscv_mem_arbiter with a behavioural
//   DRAM model and a reference memory / round-robin model.
module tb_riscv_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 10;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_rden = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic          dmem_rden = 1'b0;
  logic          dmem_wren = 1'b0;
  logic [AW-1:0] dmem_addr = '0;
  logic [DW-1:0] dmem_wdata = '0;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;
  logic          timeout;

  riscv_mem_arbiter #(
    .DATA_WIDTH (DW),
    .S_ADDR     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_riscv_arb_clk       (clk),
    .i_riscv_arb_rst       (rst),
    .i_riscv_arb_imem_rden (imem_rden),
    .i_riscv_arb_imem_addr (imem_addr),
    .o_riscv_arb_imem_ready(imem_ready),
    .o_riscv_arb_imem_rdata(imem_rdata),
    .i_riscv_arb_dmem_rden (dmem_rden),
    .i_riscv_arb_dmem_wren (dmem_wren),
    .i_riscv_arb_dmem_addr (dmem_addr),
    .i_riscv_arb_dmem_wdata(dmem_wdata),
    .o_riscv_arb_dmem_ready(dmem_ready),
    .o_riscv_arb_dmem_rdata(dmem_rdata),
    .o_riscv_arb_mem_rden  (mem_rden),
    .o_riscv_arb_mem_wren  (mem_wren),
    .o_riscv_arb_mem_addr  (mem_addr),
    .o_riscv_arb_mem_wdata (mem_wdata),
    .i_riscv_arb_mem_rdata (mem_rdata),
    .i_riscv_arb_mem_ready (mem_ready),
    .o_riscv_arb_grant     (grant),
    .o_riscv_arb_timeout   (timeout)
  );

  always #5 clk = ~clk;

  // initial DRAM contents, shared by the DRAM model and the reference memory
  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return {h, ~h, h ^ 32'h5A5A5A5A, h + 32'd7};
  endfunction

  // ---------------- DRAM model: responds dram_lat cycles after a request ----
  int            dram_lat  = 4;
  bit            dram_hang = 1'b0;
  int            dram_cnt  = 0;
  logic [DW-1:0] dram [1024];
  bit            dram_w [1024];

  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      dram_cnt  <= 0;
    end else begin
      mem_ready <= 1'b0;
      if ((mem_rden || mem_wren) && !mem_ready && !dram_hang) begin
        if (dram_cnt >= dram_lat - 1) begin
          mem_ready <= 1'b1;
          dram_cnt  <= 0;
          mem_rdata <= dram_w[mem_addr] ? dram[mem_addr] : init_word(int'(mem_addr));
          if (mem_wren) begin
            dram[mem_addr]   <= mem_wdata;
            dram_w[mem_addr] <= 1'b1;
          end
        end else begin
          dram_cnt <= dram_cnt + 1;
        end
      end else if (!(mem_rden || mem_wren)) begin
        dram_cnt <= 0;
      end
    end
  end

  // ---------------- checking state ------------------------------------------
  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [1024];
  int            model_last = 0;       // 0 = I served last, 1 = D served last
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  int            obs_rd, obs_wr;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata;
  logic [1:0]    obs_grant;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {mem_rden, mem_wren, imem_ready, dmem_ready, grant, timeout, mem_addr}, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_irdata"}, imem_rdata, '0);
    chk({tag, "_drdata"}, dmem_rdata, '0);
  endtask

  // Waits for a ready pulse (bounded); records what the DRAM side saw.
  // raise_i_at >= 0 asserts the icache request at that cycle of the wait.
  task automatic wait_done(output int who, input int budget, input int raise_i_at, input logic [AW-1:0] ia);
    who = 0; obs_rd = 0; obs_wr = 0; obs_grant = 2'b00;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == raise_i_at) begin
        imem_addr = ia;
        imem_rden = 1'b1;
      end
      chk("mem_excl", {mem_rden, mem_wren}, (mem_rden && mem_wren) ? 2'b00 : {mem_rden, mem_wren});
      if (mem_rden) begin obs_rd++; obs_addr = mem_addr; end
      if (mem_wren) begin obs_wr++; obs_addr = mem_addr; obs_wdata = mem_wdata; end
      if (imem_ready || dmem_ready) begin
        chk("one_ready", {imem_ready, dmem_ready}, imem_ready ? 2'b10 : 2'b01);
        chk("release_grant", grant, 2'b00);
        who = imem_ready ? 1 : 2;
        break;
      end
      if (grant != 2'b00) obs_grant = grant;
    end
  endtask

  // One arbitration round; completion order predicted by the round-robin rule.
  task automatic run_round(input bit ie, input bit de, input bit dw, input bit stag,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    int first, exp_who, who, n;
    if (de) begin
      dmem_addr = da; dmem_wdata = dwd; dmem_wren = dw; dmem_rden = ~dw;
    end
    if (ie && !(stag && de)) begin
      imem_addr = ia; imem_rden = 1'b1;
    end
    if (ie && de && !stag) first = (model_last == 0) ? 2 : 1;
    else if (de)           first = 2;
    else                   first = 1;
    n = int'(ie) + int'(de);
    for (int k = 0; k < n; k++) begin
      exp_who = (k == 0) ? first : 3 - first;
      wait_done(who, 60, (k == 0 && stag && ie && de) ? 1 : -1, ia);
      chk("who", who, exp_who);
      chk("grant", obs_grant, (exp_who == 1) ? 2'b01 : 2'b10);
      chk("lat_cycles", obs_rd + obs_wr, dram_lat + 1);
      if (exp_who == 1) begin
        exp_i_rdata = ref_mem[ia];
        chk("i_op", obs_wr, 0);
        chk("i_addr", obs_addr, ia);
        chk("i_rdata", imem_rdata, exp_i_rdata);
        chk("d_rdata_hold", dmem_rdata, exp_d_rdata);
        imem_rden = 1'b0;
        model_last = 0;
      end else begin
        chk("d_addr", obs_addr, da);
        if (dw) begin
          chk("d_wr_op", obs_rd, 0);
          chk("d_wdata", obs_wdata, dwd);
          ref_mem[da] = dwd;
        end else begin
          chk("d_rd_op", obs_wr, 0);
          exp_d_rdata = ref_mem[da];
        end
        chk("d_rdata", dmem_rdata, exp_d_rdata);
        chk("i_rdata_hold", imem_rdata, exp_i_rdata);
        dmem_rden = 1'b0; dmem_wren = 1'b0;
        model_last = 1;
      end
      @(negedge clk);
      chk("single_pulse", {imem_ready, dmem_ready}, 2'b00);
    end
  endtask

  // ---------------- directed + random sequence -------------------------------
  initial begin
    int who;
    logic [AW-1:0] ra;
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(a);

    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // D write alone, then a fill of 0xAA.. at 0x05, then icache read of it
    dram_lat = 4;
    run_round(0, 1, 1, 0, 10'h000, 10'h3FF, 128'h1234);
    run_round(0, 1, 1, 0, 10'h000, 10'h005, {16{8'hAA}});
    run_round(1, 0, 0, 0, 10'h005, 10'h000, '0);
    chk("i_read_aa", imem_rdata, {16{8'hAA}});
    run_round(0, 1, 0, 0, 10'h000, 10'h3FF, '0);
    chk("d_read_1234", dmem_rdata, 128'h1234);

    // reset again so D wins the first tie; ties then alternate D, I, D, I
    rst = 1'b1;
    #1 chk_all_zero("reset2");
    @(negedge clk);
    rst = 1'b0;
    model_last = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      run_round(1, 1, 0, 0, 10'(t + 32), 10'(t + 64), '0);
    end

    // icache request arrives while dcache is granted
    for (int t = 0; t < 2; t++) begin
      run_round(1, 1, 0, 1, 10'(t + 100), 10'(t + 200), '0);
    end

    // randomized rounds
    for (int t = 0; t < 14; t++) begin
      bit ie, de, dw, st;
      ie = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      if (!ie && !de) ie = 1'b1;
      dw = 1'($urandom_range(0, 1));
      st = ie && de && ($urandom_range(0, 3) == 0);
      dram_lat = $urandom_range(1, 5);
      // small address pool so writes and reads collide
      run_round(ie, de, dw, st, 10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)),
                {$urandom, $urandom, $urandom, $urandom});
    end

    // timeout: DRAM stalls, flag rises after TO grant cycles, grant still completes
    dram_lat = 3;
    dram_hang = 1'b1;
    ra = 10'h0F0;
    dmem_addr = ra; dmem_rden = 1'b1;
    repeat (TO) @(negedge clk);
    chk("to_grant", grant, 2'b10);
    chk("to_before", timeout, 1'b0);
    @(negedge clk);
    chk("to_set", timeout, 1'b1);
    dram_hang = 1'b0;
    wait_done(who, 60, -1, '0);
    chk("to_who", who, 2);
    exp_d_rdata = ref_mem[ra];
    chk("to_rdata", dmem_rdata, exp_d_rdata);
    dmem_rden = 1'b0;
    model_last = 1;
    @(negedge clk);
    run_round(1, 0, 0, 0, 10'h0F1, '0, '0);
    chk("to_sticky", timeout, 1'b1);

    // reset in the middle of a dcache grant
    dram_lat = 4;
    ra = 10'h123;
    dmem_addr = ra; dmem_rden = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_grant", grant, 2'b10);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_ready", dmem_ready, 1'b0);
    end
    rst = 1'b0;
    model_last = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    wait_done(who, 60, -1, '0);
    chk("regrant_who", who, 2);
    chk("regrant_lat", obs_rd, dram_lat + 1);
    chk("regrant_rdata", dmem_rdata, ref_mem[ra]);
    chk("regrant_to", timeout, 1'b0);
    dmem_rden = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one backing DRAM port between the icache refill FSM (read-only) and the dcache FSM (read/write-back).
- Sits between riscv_core and a single riscv_dram_model, replacing the separate imem/dmem memory paths.
- Uses round-robin arbitration with one outstanding transaction at a time, registered responses, and a sticky timeout flag for debug.

Parameters:
- DATA_WIDTH, 128, cache block width in bits
- S_ADDR, 10, block address width (ADDR - BYTE_OFF)
- TIMEOUT_CYC, 1023, max cycles in a grant state before the timeout flag sets

Ports:
- i_riscv_arb_clk  in  1  clock
- i_riscv_arb_rst  in  1  asynchronous, active-high reset
- i_riscv_arb_imem_rden  in  1  icache read request; level, held until its ready
- i_riscv_arb_imem_addr  in  S_ADDR  icache block address
- o_riscv_arb_imem_ready  out  1  one-cycle icache completion pulse
- o_riscv_arb_imem_rdata  out  DATA_WIDTH  icache read block
- i_riscv_arb_dmem_rden  in  1  dcache read request; level
- i_riscv_arb_dmem_wren  in  1  dcache write request; level
- i_riscv_arb_dmem_addr  in  S_ADDR  dcache block address
- i_riscv_arb_dmem_wdata  in  DATA_WIDTH  dcache write block
- o_riscv_arb_dmem_ready  out  1  one-cycle dcache completion pulse
- o_riscv_arb_dmem_rdata  out  DATA_WIDTH  dcache read block
- o_riscv_arb_mem_rden  out  1  DRAM read enable
- o_riscv_arb_mem_wren  out  1  DRAM write enable
- o_riscv_arb_mem_addr  out  S_ADDR  DRAM block address
- o_riscv_arb_mem_wdata  out  DATA_WIDTH  DRAM write data
- i_riscv_arb_mem_rdata  in  DATA_WIDTH  DRAM read data, valid with mem_ready
- i_riscv_arb_mem_ready  in  1  DRAM completion pulse
- o_riscv_arb_grant  out  2  debug: 01 = I granted, 10 = D granted, 00 = none
- o_riscv_arb_timeout  out  1  sticky timeout error

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = I (so D wins the first tie), timeout counter 0. Reset mid-transaction aborts it; no ready pulse is issued.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE: requester I is valid when imem_rden = 1; requester D is valid when dmem_rden | dmem_wren = 1.
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - On the grant edge: latch addr (and wdata for D), update last_grant, move to GRANT_x.
  - All mem_* outputs are registered, so the DRAM request appears one cycle after the request is sampled.
- GRANT_I: mem_rden = 1, mem_wren = 0.
- GRANT_D: if wren = 1, drive mem_wren = 1 (wren wins when both are set, rden ignored); else drive mem_rden = 1. The op is latched at grant.
- In GRANT_x, i_mem_ready = 1 at an edge moves to RELEASE and:
  - deasserts mem_rden/mem_wren;
  - pulses o_x_ready = 1 for exactly the RELEASE cycle;
  - for reads, registers i_mem_rdata into o_x_rdata. Writes leave rdata unchanged.
- RELEASE -> IDLE unconditionally. This guarantees one idle memory cycle so the DRAM model rearms, and the requester drops its request on the ready edge. Earliest next grant is one cycle after RELEASE.
- Turnaround: minimum 3 cycles request-to-ready plus DRAM latency.
- o_x_rdata holds its last value until the next read for that requester.
- i_mem_ready in IDLE or RELEASE is ignored.
- Requests arriving while the other requester is granted wait; they are not lost, because requests are levels.
- Timeout counter:
  - counts cycles spent in a GRANT state and clears in IDLE;
  - when it reaches TIMEOUT_CYC, o_timeout sets and stays 1 until reset;
  - the grant is not aborted; the counter saturates.
- o_grant is decoded from state and is 00 in IDLE and RELEASE.
- Never drives mem_rden and mem_wren together; never issues a ready pulse to the non-granted requester.

Test Plan:
- I only: imem_rden = 1, addr = 0x05; DRAM returns 0xAA..AA after 4 cycles -> mem_rden high with addr 0x05 for exactly those cycles; one imem_ready pulse; imem_rdata = 0xAA..AA; dmem_ready stays 0.
- D write: dmem_wren = 1, addr = 0x3FF, wdata = 0x1234 -> mem_wren = 1, mem_wdata = 0x1234, mem_addr = 0x3FF; dmem_ready pulse; dmem_rdata unchanged.
- Tie after reset: imem_rden and dmem_rden both asserted in the same cycle, repeated -> grant order D, I, D, I; o_grant = 10, 01, 10, 01; one RELEASE cycle between each.
- Back-to-back: D reading while I asserts mid-grant -> I is served right after RELEASE/IDLE; no ready pulse crosses to the wrong requester.
- Timeout: TIMEOUT_CYC = 8, DRAM never readies -> o_timeout rises after 8 cycles in GRANT; a later mem_ready still completes the grant; the flag stays 1.
- Reset mid-grant: assert rst while in GRANT_D -> outputs 0 asynchronously, no dmem_ready; after release, a held request is re-granted from IDLE.
